// File: rtl/simeck_load_seq.sv
// simeck_load_seq: load/round sequencer for the Simeck datapath.
// A request (income && ready) captures mode/Data/Key into shadow registers.
// The sequencer then streams KEYWORDS key words (kctr/save strobes) and two
// data halves (dctr strobe), times ROUNDS round cycles and pulses done.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   income, mode        request valid, 0=encrypt / 1=decrypt
//   Data, Key           block and master key, sampled on accept
//   ready               sequencer can accept a request
//   keyout, kctr, save  key word to key-schedule + load/capture strobes
//   dataout, dctr       data half to round datapath + load strobe
//   set, lfsrset, dec   datapath idle, LFSR held at seed, latched mode
//   round_idx, done     round counter during RUN, end-of-run pulse
module simeck_load_seq #(
  parameter int DATAW    = 16,
  parameter int KEYWORDS = 4,
  parameter int ROUNDS   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      income,
  input  logic                      mode,
  input  logic [2*DATAW-1:0]        Data,
  input  logic [KEYWORDS*DATAW-1:0] Key,
  output logic                      ready,
  output logic [DATAW-1:0]          keyout,
  output logic [DATAW-1:0]          dataout,
  output logic                      kctr,
  output logic                      dctr,
  output logic                      save,
  output logic                      set,
  output logic                      lfsrset,
  output logic                      dec,
  output logic [7:0]                round_idx,
  output logic                      done
);

  localparam int KW = $clog2(KEYWORDS + 1);   // holds 0..KEYWORDS
  localparam int IW = $clog2(KEYWORDS);       // key word index
  localparam logic [KW-1:0] KLAST = KW'(KEYWORDS);
  localparam logic [7:0]    RLAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOADK, S_LOADD, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic                               mode;
    logic [2*DATAW-1:0]                 data;
    logic [KEYWORDS-1:0][DATAW-1:0]     key;
  } req_t;

  state_t                         state;
  req_t                           req_q;
  logic [KW-1:0]                  kcnt;   // key words emitted so far
  logic                           dhalf;  // second data half in flight
  logic [KEYWORDS-1:0][DATAW-1:0] key_in;
  logic [IW-1:0]                  first_idx;
  logic [IW-1:0]                  next_idx;
  logic                           accept;

  assign key_in = Key;

  // A DONE cycle also accepts, so back-to-back blocks skip IDLE entirely.
  assign accept = income && ((state == S_IDLE && ready) || state == S_DONE);

  always_comb begin
    first_idx = mode ? IW'(KEYWORDS - 1) : '0;
    next_idx  = req_q.mode ? (IW'(KEYWORDS - 1) - IW'(kcnt)) : IW'(kcnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      kcnt      <= '0;
      dhalf     <= 1'b0;
      ready     <= 1'b1;
      keyout    <= '0;
      dataout   <= '0;
      kctr      <= 1'b0;
      dctr      <= 1'b0;
      save      <= 1'b0;
      set       <= 1'b1;
      lfsrset   <= 1'b1;
      dec       <= 1'b0;
      round_idx <= '0;
      done      <= 1'b0;
    end else if (accept) begin
      req_q     <= '{mode: mode, data: Data, key: key_in};
      keyout    <= key_in[first_idx];
      kcnt      <= KW'(1);
      dhalf     <= 1'b0;
      state     <= S_LOADK;
      ready     <= 1'b0;
      kctr      <= 1'b1;
      dctr      <= 1'b0;
      save      <= 1'b1;
      set       <= 1'b0;
      lfsrset   <= 1'b1;
      dec       <= mode;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LOADK: begin
          if (kcnt == KLAST) begin
            state   <= S_LOADD;
            kctr    <= 1'b0;
            save    <= 1'b0;
            dctr    <= 1'b1;
            dhalf   <= 1'b0;
            dataout <= req_q.mode ? req_q.data[2*DATAW-1:DATAW]
                                  : req_q.data[DATAW-1:0];
          end else begin
            keyout <= req_q.key[next_idx];
            kcnt   <= kcnt + KW'(1);
          end
        end
        S_LOADD: begin
          if (!dhalf) begin
            dhalf   <= 1'b1;
            dataout <= req_q.mode ? req_q.data[DATAW-1:0]
                                  : req_q.data[2*DATAW-1:DATAW];
          end else begin
            state     <= S_RUN;
            dctr      <= 1'b0;
            lfsrset   <= 1'b0;
            round_idx <= '0;
          end
        end
        S_RUN: begin
          if (round_idx == RLAST) begin
            state     <= S_DONE;
            done      <= 1'b1;
            lfsrset   <= 1'b1;
            round_idx <= '0;
          end else begin
            round_idx <= round_idx + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          set   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simeck_load_seq.sv
module tb_simeck_load_seq;

  localparam int K = 4;
  localparam int R = 32;
  localparam int DONE_OFF = K + 3 + R;   // 39

  logic clk, rst_n;

  // default instance (A)
  logic        income, mode;
  logic [31:0] Data;
  logic [63:0] Key;
  logic        ready, kctr, dctr, save, set, lfsrset, dec, done;
  logic [15:0] keyout, dataout;
  logic [7:0]  round_idx;

  // wide instance (B): DATAW=32, ROUNDS=44
  logic         b_income, b_mode;
  logic [63:0]  b_Data;
  logic [127:0] b_Key;
  logic         b_ready, b_kctr, b_dctr, b_save, b_set, b_lfsrset, b_dec, b_done;
  logic [31:0]  b_keyout, b_dataout;
  logic [7:0]   b_round_idx;

  simeck_load_seq dut (
    .clk(clk), .rst_n(rst_n), .income(income), .mode(mode), .Data(Data), .Key(Key),
    .ready(ready), .keyout(keyout), .dataout(dataout), .kctr(kctr), .dctr(dctr),
    .save(save), .set(set), .lfsrset(lfsrset), .dec(dec), .round_idx(round_idx),
    .done(done));

  simeck_load_seq #(.DATAW(32), .KEYWORDS(4), .ROUNDS(44)) dut_b (
    .clk(clk), .rst_n(rst_n), .income(b_income), .mode(b_mode), .Data(b_Data), .Key(b_Key),
    .ready(b_ready), .keyout(b_keyout), .dataout(b_dataout), .kctr(b_kctr), .dctr(b_dctr),
    .save(b_save), .set(b_set), .lfsrset(b_lfsrset), .dec(b_dec), .round_idx(b_round_idx),
    .done(b_done));

  typedef struct packed {
    logic             mode;
    logic [63:0]      key;
    logic [31:0]      data;
    logic [3:0][15:0] kw;   // kw[0] is the first word expected on keyout
    logic [1:0][15:0] dw;   // dw[0] is the first half expected on dataout
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [15:0] qk[$];
  logic [15:0] qd[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < 4; i++) qk.push_back(v.kw[i]);
    qd.push_back(v.dw[0]);
    qd.push_back(v.dw[1]);
  endtask

  task automatic drive(input vec_t v);
    mode = v.mode; Key = v.key; Data = v.data;
  endtask

  // one-cycle request; returns just after the accept edge
  task automatic send(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    push_exp(v);
    income = 1'b1;
    @(posedge clk); #1;
    income = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 200);
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within %0d cycles", name, lat);
    end
  endtask

  // Per-cycle scoreboard/monitor for instance A. Expected control values come
  // from the offset since the accept edge; key/data words from the queues.
  initial begin
    bit active = 0, pend = 0, pend_mode = 0, exp_dec = 0;
    int off = 0;
    logic [15:0] lastk = '0, lastd = '0, ek, ed;
    logic [7:0]  ec, cm, er;
    logic [15:0] km, dm;
    logic [47:0] act, exp, msk;
    forever begin
      @(negedge clk);
      ek = lastk; ed = lastd; er = 8'd0;
      if (!rst_n) begin
        qk.delete(); qd.delete();
        active = 0; pend = 0; exp_dec = 0; lastk = '0; lastd = '0;
        ec = 8'b1000_1100; cm = 8'hFF; ek = '0; ed = '0; km = 16'hFFFF; dm = 16'hFFFF;
      end else begin
        if (pend) begin
          active = 1; off = 1; pend = 0; exp_dec = pend_mode;
        end else if (active) begin
          off++;
          if (off > DONE_OFF) active = 0;
        end
        km = 16'h0; dm = 16'h0; cm = 8'hFF;
        if (!active) begin
          ec = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_dec, 1'b0};
        end else if (off <= K) begin
          ec = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_dec, 1'b0};
          cm = 8'hFB;
          km = 16'hFFFF;
          if (qk.size() == 0) begin n_cmp++; n_bad++; $display("FAIL sb_key_underflow off=%0d", off); end
          else ek = qk.pop_front();
          lastk = ek;
        end else if (off <= K + 2) begin
          ec = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_dec, 1'b0};
          dm = 16'hFFFF;
          if (qd.size() == 0) begin n_cmp++; n_bad++; $display("FAIL sb_data_underflow off=%0d", off); end
          else ed = qd.pop_front();
          lastd = ed;
        end else if (off < DONE_OFF) begin
          ec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_dec, 1'b0};
          er = 8'(off - K - 3);
          km = 16'hFFFF; dm = 16'hFFFF;
        end else begin
          ec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_dec, 1'b1};
          cm = 8'hF7;
        end
        if (income && (!active || off == DONE_OFF)) begin
          pend = 1; pend_mode = mode;
        end
      end
      act = {ready, kctr, dctr, save, set, lfsrset, dec, done, round_idx, keyout, dataout};
      exp = {ec, er, ek, ed};
      msk = {cm, 8'hFF, km, dm};
      n_cmp++;
      if ((act & msk) !== (exp & msk)) begin
        n_bad++;
        $display("FAIL cycle rst=%0b off=%0d: got %h want %h (mask %h)",
                 rst_n, off, act & msk, exp & msk, msk);
      end
    end
  end

  vec_t vt[4];

  initial begin
    int lat, t1, t2, b_done_off, b_ndone, b_max, b_nd;
    logic [3:0][31:0] bkw;
    vt[0] = '{1'b0, 64'h1918_1110_0908_0100, 32'h6565_6877,
              {16'h1918, 16'h1110, 16'h0908, 16'h0100}, {16'h6565, 16'h6877}};
    vt[1] = '{1'b1, 64'h1918_1110_0908_0100, 32'h6565_6877,
              {16'h0100, 16'h0908, 16'h1110, 16'h1918}, {16'h6877, 16'h6565}};
    vt[2] = '{1'b0, 64'hdead_beef_0123_4567, 32'hcafe_f00d,
              {16'hdead, 16'hbeef, 16'h0123, 16'h4567}, {16'hcafe, 16'hf00d}};
    vt[3] = '{1'b1, 64'h0001_0002_0003_0004, 32'h8000_0001,
              {16'h0004, 16'h0003, 16'h0002, 16'h0001}, {16'h0001, 16'h8000}};

    rst_n = 1'b0; income = 1'b0; mode = 1'b0; Data = '0; Key = '0;
    b_income = 1'b0; b_mode = 1'b0; b_Data = '0; b_Key = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // table-driven single requests
    for (int i = 0; i < 4; i++) begin
      send(vt[i]);
      wait_done($sformatf("vec%0d_done", i), lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(DONE_OFF));
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after", i), 64'(ready), 64'd1);
      repeat (2) @(posedge clk);
    end

    // back-to-back: income held high across the DONE cycle
    @(posedge clk); #1;
    drive(vt[0]); push_exp(vt[0]); push_exp(vt[1]);
    income = 1'b1;
    @(posedge clk); #1;
    drive(vt[1]);
    wait_done("b2b_done1", lat);
    t1 = cyc;
    chk("b2b_latency1", 64'(lat), 64'(DONE_OFF));
    @(posedge clk); #1 income = 1'b0;
    wait_done("b2b_done2", lat);
    t2 = cyc;
    chk("b2b_done_gap", 64'(t2 - t1), 64'(DONE_OFF));
    repeat (3) @(posedge clk);

    // shadowing: inputs change at +2, stray income pulse at +10
    send(vt[2]);
    @(posedge clk); #1 drive(vt[3]);
    repeat (8) @(posedge clk);
    #1 income = 1'b1;
    @(posedge clk); #1 income = 1'b0;
    wait_done("shadow_done", lat);
    chk("shadow_latency", 64'(lat + 10), 64'(DONE_OFF));
    repeat (3) @(posedge clk);

    // reset abort during RUN
    send(vt[1]);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abort_outs",
        {40'd0, ready, kctr, dctr, save, set, lfsrset, dec, done, round_idx, keyout, dataout},
        {40'd0, 8'b1000_1100, 8'd0, 16'd0, 16'd0});
    lat = 0;
    repeat (2) begin @(negedge clk); lat += int'(done); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(negedge clk); lat += int'(done); end
    chk("rst_no_done", 64'(lat), 64'd0);
    send(vt[0]);
    wait_done("post_rst_done", lat);
    chk("post_rst_latency", 64'(lat), 64'(DONE_OFF));
    repeat (3) @(posedge clk);

    // wide configuration: DATAW=32, ROUNDS=44
    bkw = {32'h1b1a1918, 32'h13121110, 32'h0b0a0908, 32'h03020100};
    @(posedge clk); #1;
    b_mode = 1'b0;
    b_Key  = 128'h1b1a1918_13121110_0b0a0908_03020100;
    b_Data = 64'h656b696c_20646e75;
    b_income = 1'b1;
    @(posedge clk); #1 b_income = 1'b0;
    b_done_off = 0; b_ndone = 0; b_max = 0; b_nd = 0;
    for (int o = 1; o <= 60; o++) begin
      @(negedge clk);
      if (o <= 4) chk($sformatf("b_key%0d", o), {31'd0, b_kctr, b_keyout}, {31'd0, 1'b1, bkw[o-1]});
      if (o == 5) chk("b_data_lo", {31'd0, b_dctr, b_dataout}, {31'd0, 1'b1, 32'h20646e75});
      if (o == 6) chk("b_data_hi", {31'd0, b_dctr, b_dataout}, {31'd0, 1'b1, 32'h656b696c});
      if (b_dctr) b_nd++;
      if (b_done) begin b_ndone++; b_done_off = o; end
      if (int'(b_round_idx) > b_max) b_max = int'(b_round_idx);
    end
    chk("b_dctr_cycles", 64'(b_nd), 64'd2);
    chk("b_round_max", 64'(b_max), 64'd43);
    chk("b_done_off", 64'(b_done_off), 64'd51);
    chk("b_done_count", 64'(b_ndone), 64'd1);
    chk("b_ready_end", 64'(b_ready), 64'd1);

    chk("sb_drained", 64'(qk.size() + qd.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
